bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
Shares one BRAM port (xilinx_true_dual_port_read_first_2_clock_ram port A) among NUM_REQ requesters, e.g. the comms module and the compute engine, over the data, weight and op memories. It accepts valid/ready requests and arbitrates them by fixed priority or round robin. Requesters can lock the port for read-modify-write sequences. It drives the BRAM address, data, write-enable and output-register-enable signals, and returns read data with a per-requester valid after the configured RAM read latency.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
RAM_WIDTH, 64, data width in bits
RAM_DEPTH, 16384, words; ADDR_W = $clog2(RAM_DEPTH)
READ_LATENCY, 2, BRAM read latency: 2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
req_valid_in  in  NUM_REQ  request valid, one bit per requester
req_ready_out  out  NUM_REQ  request accepted this cycle; at most one bit high
req_we_in  in  NUM_REQ  1 = write, 0 = read
req_lock_in  in  NUM_REQ  hold the grant after this beat
req_addr_in  in  NUM_REQ x ADDR_W  word address
req_wdata_in  in  NUM_REQ x RAM_WIDTH  write data
rsp_valid_out  out  NUM_REQ  read data valid for this requester
rsp_data_out  out  RAM_WIDTH  read data, shared by all requesters; qualified by rsp_valid_out
ram_addr_out  out  ADDR_W  to BRAM addra
ram_din_out  out  RAM_WIDTH  to BRAM dina
ram_we_out  out  1  to BRAM wea
ram_regce_out  out  1  to BRAM regcea
ram_dout_in  in  RAM_WIDTH  from BRAM douta

Behaviour:
- Reset values: ram_addr_out = 0, ram_din_out = 0, ram_we_out = 0, ram_regce_out = 0, rsp_valid_out = 0. The lock is cleared. The round-robin pointer = 0. The tag pipeline is cleared.
- Handshake: a beat is accepted when req_valid_in[i] and req_ready_out[i] are both high. req_ready_out may depend combinationally on req_valid_in. Requesters must not make valid depend on ready. Valid, address, data and we stay stable until accepted.
- Grant with the lock free:
  - ARB_MODE 0: the lowest index with valid is granted.
  - ARB_MODE 1: the first valid index at or after the pointer, wrapping modulo NUM_REQ, is granted. After each accepted beat the pointer becomes granted index + 1, with wrap-around.
- Lock:
  - An accepted beat with req_lock_in high sets the lock owner to that requester.
  - While the lock is held, only the owner can be ready. The port idles if the owner is not valid.
  - The lock releases on the owner's next accepted beat with req_lock_in low. That beat still completes normally.
- Port pipeline: a beat accepted at cycle T appears on ram_addr_out, ram_din_out and ram_we_out at T+1 (registered). With no accepted beat, ram_we_out = 0 the next cycle and ram_addr_out holds its value.
- Reads:
  - A tag of {valid, requester index} enters a READ_LATENCY-deep shift register at T+1.
  - READ_LATENCY = 2: ram_regce_out is high at T+2, the cycle the BRAM latch transfers into the output register.
  - READ_LATENCY = 1: ram_regce_out is tied to 1.
  - rsp_valid_out[idx] pulses for one cycle at T+1+READ_LATENCY.
  - rsp_data_out = ram_dout_in, combinational pass-through.
- Writes generate no tag and no response. Read-first RAM semantics are irrelevant because a single port carries at most one operation per cycle.
- Back-to-back: one beat can be accepted every cycle. Responses return in issue order with full throughput.
- Reset mid-operation: in-flight read tags are discarded, so no rsp_valid_out follows for reads accepted before reset. The lock and pointer clear. Beats presented during reset are not accepted (req_ready_out = 0 while rst_in is high).
- NUM_REQ = 1: the grant reduces to valid, and the lock has no observable effect.

Decomposition:
- Package bram_arb_pkg: ARB_FIXED = 0, ARB_RR = 1; function to compute the requester index width; typedef for the tag struct {logic valid; logic [IDX_W-1:0] idx;}.
- Sub-module rr_arbiter: combinational grant from the valid, pointer, mode and lock inputs, plus the pointer register. The top of this block holds the lock register, the port registers and the tag pipeline.

Test Plan:
1. Single read, preloaded word 5 = 64'hDEAD_BEEF_0123_4567, READ_LATENCY 2: req0 reads address 5, accepted at T -> ram_addr_out = 5 at T+1, ram_regce_out at T+2, rsp_valid_out = 2'b01 with data 64'hDEAD_BEEF_0123_4567 at T+3.
2. Fixed priority, ARB_MODE 0: both requesters valid for 4 cycles -> req_ready_out = 2'b01 on all 4 cycles. req1 is accepted on the first cycle req0 drops valid.
3. Round robin, ARB_MODE 1: both requesters issue continuous reads to addresses 0..5 -> grants alternate 0,1,0,1,0,1. Responses arrive every cycle in the same order, and each carries the matching requester's data.
4. Lock: req1 writes address 10 = 64'h1 with lock high, then req0 is valid -> req0 is not ready until req1 reads address 10 (lock high) and then writes 64'h2 (lock low). A final read of address 10 returns 64'h2.
5. Reset mid-flight: a read is accepted at T and rst_in is high at T+1 -> no rsp_valid_out at T+3, and all outputs equal their reset values at T+2.
6. READ_LATENCY 1, with word 7 = 64'hAA: a read of address 7 accepted at T -> ram_regce_out is constant 1, and rsp_valid_out is high at T+2 with data 64'hAA.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package bram_arb_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int IDX_MAX_W = 3;  // wide enough for up to 8 requesters

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant (fixed priority or round robin, lock-aware) plus the round-robin pointer.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int IDX_W    = idx_width(NUM_REQ)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_lock_held,
  input  logic [IDX_W-1:0]   i_lock_owner,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_idx
);
  logic [IDX_W-1:0] r_ptr;

  always_comb begin : p_grant
    int j;
    j       = 0;
    o_grant = '0;
    o_any   = 1'b0;
    o_idx   = '0;
    if (!rst_in) begin
      if (i_lock_held) begin
        if (i_valid[i_lock_owner]) begin
          o_any = 1'b1;
          o_idx = i_lock_owner;
        end
      end else begin
        // Scan starting at the pointer (or at 0 for fixed priority), wrapping once.
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (ARB_MODE == ARB_RR) ? int'(r_ptr) + k : k;
          if (j >= NUM_REQ) j = j - NUM_REQ;
          if (!o_any && i_valid[j]) begin
            o_any = 1'b1;
            o_idx = IDX_W'(j);
          end
        end
      end
      if (o_any) o_grant[o_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ptr <= '0;
    end else if (o_any && (ARB_MODE == ARB_RR)) begin
      r_ptr <= (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NUM_REQ valid/ready requesters with lock support and tagged read return.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int RAM_WIDTH    = 64,
  parameter int RAM_DEPTH    = 16384,
  parameter int READ_LATENCY = 2,
  parameter int ARB_MODE     = ARB_FIXED,
  localparam int ADDR_W      = $clog2(RAM_DEPTH)
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  input  logic [NUM_REQ-1:0]                req_we_in,
  input  logic [NUM_REQ-1:0]                req_lock_in,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr_in,
  input  logic [NUM_REQ-1:0][RAM_WIDTH-1:0] req_wdata_in,
  output logic [NUM_REQ-1:0]                rsp_valid_out,
  output logic [RAM_WIDTH-1:0]              rsp_data_out,
  output logic [ADDR_W-1:0]                 ram_addr_out,
  output logic [RAM_WIDTH-1:0]              ram_din_out,
  output logic                              ram_we_out,
  output logic                              ram_regce_out,
  input  logic [RAM_WIDTH-1:0]              ram_dout_in
);
  localparam int IDX_W = idx_width(NUM_REQ);

  logic                 r_lock_held;
  logic [IDX_W-1:0]     r_lock_owner;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_any;
  logic [IDX_W-1:0]     w_idx;
  logic [ADDR_W-1:0]    r_addr;
  logic [RAM_WIDTH-1:0] r_din;
  logic                 r_we;
  // Stage 0 rides alongside the port registers; the last stage lines up with douta.
  tag_t                 r_tag_pipe [READ_LATENCY:0];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ARB_MODE(ARB_MODE), .IDX_W(IDX_W)) u_arb (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_valid      (req_valid_in),
    .i_lock_held  (r_lock_held),
    .i_lock_owner (r_lock_owner),
    .o_grant      (w_grant),
    .o_any        (w_any),
    .o_idx        (w_idx)
  );

  assign req_ready_out = w_grant;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_lock_held  <= 1'b0;
      r_lock_owner <= '0;
      r_addr       <= '0;
      r_din        <= '0;
      r_we         <= 1'b0;
    end else begin
      r_we <= w_any && req_we_in[w_idx];
      if (w_any) begin
        r_addr       <= req_addr_in[w_idx];
        r_din        <= req_wdata_in[w_idx];
        // Only the owner can be granted while locked, so its unlocked beat releases.
        r_lock_held  <= req_lock_in[w_idx];
        r_lock_owner <= w_idx;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k <= READ_LATENCY; k++) r_tag_pipe[k] <= '0;
    end else begin
      r_tag_pipe[0] <= '{valid: w_any && !req_we_in[w_idx], idx: IDX_MAX_W'(w_idx)};
      for (int k = 1; k <= READ_LATENCY; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
    end
  end

  always_comb begin
    rsp_valid_out = '0;
    if (r_tag_pipe[READ_LATENCY].valid)
      rsp_valid_out[r_tag_pipe[READ_LATENCY].idx[IDX_W-1:0]] = 1'b1;
  end

  generate
    if (READ_LATENCY == 1) begin : g_regce_tied
      assign ram_regce_out = 1'b1;
    end else begin : g_regce_tag
      assign ram_regce_out = r_tag_pipe[1].valid;
    end
  endgenerate

  assign rsp_data_out = ram_dout_in;
  assign ram_addr_out = r_addr;
  assign ram_din_out  = r_din;
  assign ram_we_out   = r_we;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench: four arbiter configurations, each against a BRAM model and a transaction-level reference.
module tb_bram_port_arbiter;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NCYC  = 600;

  logic clk = 1'b0;
  logic ld;
  int   errs   = 0;
  int   checks = 0;
  bit   done [4];

  typedef struct {
    int          due;
    int          idx;
    logic [63:0] d;
  } rsp_t;

  always #5 clk = ~clk;

  function automatic logic [63:0] pre(input int i);
    if (i == 5) return 64'hDEAD_BEEF_0123_4567;
    if (i == 7) return 64'hAA;
    return {32'(i) * 32'h9E37_79B1, 32'(i) ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input int c, input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL cfg%0d %s: got %h expected %h @%0t", c, tag, act, exp, $time);
    end
  endtask

  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int N    = (c == 3) ? 3 : 2;
    localparam int MODE = (c == 1 || c == 3) ? 1 : 0;
    localparam int RL   = (c >= 2) ? 1 : 2;

    logic                   rst;
    logic [N-1:0]           vld, we, lk, rdy, rsp;
    logic [N-1:0][AW-1:0]   ad;
    logic [N-1:0][63:0]     wd;
    logic [63:0]            rdata, din, dout, latch;
    logic [AW-1:0]          raddr;
    logic                   rwe, regce;
    logic [63:0]            ram [DEPTH];

    bram_port_arbiter #(
      .NUM_REQ(N), .RAM_WIDTH(64), .RAM_DEPTH(DEPTH), .READ_LATENCY(RL), .ARB_MODE(MODE)
    ) u_dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .req_valid_in  (vld),
      .req_ready_out (rdy),
      .req_we_in     (we),
      .req_lock_in   (lk),
      .req_addr_in   (ad),
      .req_wdata_in  (wd),
      .rsp_valid_out (rsp),
      .rsp_data_out  (rdata),
      .ram_addr_out  (raddr),
      .ram_din_out   (din),
      .ram_we_out    (rwe),
      .ram_regce_out (regce),
      .ram_dout_in   (dout)
    );

    // Read-first single-port BRAM with optional output register.
    always @(posedge clk) begin
      if (ld) begin
        for (int i = 0; i < DEPTH; i++) ram[i] <= pre(i);
      end else if (rwe) begin
        ram[raddr] <= din;
      end
      if (RL == 1) begin
        dout <= ram[raddr];
      end else begin
        latch <= ram[raddr];
        if (regce) dout <= latch;
      end
    end

    initial begin
      bit          pv [N];
      bit          pwe [N];
      bit          plk [N];
      logic [AW-1:0] pa [N];
      logic [63:0] pd [N];
      logic [63:0] mm [DEPTH];
      rsp_t        q [$];
      int          g, j, lo, ptr;
      logic [1:0]  rh;
      logic [63:0] ev, exp_din;
      logic [AW-1:0] exp_addr;
      logic        exp_we;

      for (int i = 0; i < DEPTH; i++) mm[i] = pre(i);
      for (int i = 0; i < N; i++) begin
        pv[i] = 0; pwe[i] = 0; plk[i] = 0; pa[i] = '0; pd[i] = '0;
      end
      rst = 1'b1; vld = '0; we = '0; lk = '0; ad = '0; wd = '0;
      lo = -1; ptr = 0; rh = '0; exp_addr = '0; exp_din = '0; exp_we = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
        @(posedge clk);
        #1;
        chk(c, "ram_we", 64'(rwe), 64'(exp_we));
        chk(c, "ram_addr", 64'(raddr), 64'(exp_addr));
        chk(c, "ram_din", din, exp_din);
        chk(c, "regce", 64'(regce), (RL == 1) ? 64'd1 : 64'(rh[1]));
        ev = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          ev = 64'(1) << q[0].idx;
          chk(c, "rsp_data", rdata, q[0].d);
          void'(q.pop_front());
        end
        chk(c, "rsp_valid", 64'(rsp), ev);

        rst = (cyc < 3) || (cyc >= 300 && cyc < 302);
        if (cyc == 3) begin
          pv[0] = 1; pwe[0] = 0; plk[0] = 0; pa[0] = AW'((RL == 1) ? 7 : 5); pd[0] = '0;
        end else if (cyc > 3) begin
          for (int i = 0; i < N; i++) begin
            if (!pv[i] && $urandom_range(0, 3) != 0) begin
              pv[i]  = 1;
              pwe[i] = ($urandom_range(0, 2) == 0);
              plk[i] = ($urandom_range(0, 4) == 0);
              pa[i]  = AW'($urandom_range(0, 15));
              pd[i]  = {$urandom, $urandom};
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          vld[i] = pv[i]; we[i] = pwe[i]; lk[i] = plk[i]; ad[i] = pa[i]; wd[i] = pd[i];
        end
        #1;

        g = -1;
        if (!rst) begin
          if (lo >= 0) begin
            g = pv[lo] ? lo : -1;
          end else begin
            for (int k = 0; k < N; k++) begin
              j = (MODE == 1) ? (ptr + k) % N : k;
              if (g < 0 && pv[j]) g = j;
            end
          end
        end
        chk(c, "ready", 64'(rdy), (g < 0) ? 64'd0 : (64'(1) << g));

        rh = {rh[0], 1'b0};
        exp_we = 1'b0;
        if (rst) begin
          q.delete();
          rh = '0; lo = -1; ptr = 0; exp_addr = '0; exp_din = '0;
        end else if (g >= 0) begin
          exp_addr = pa[g];
          exp_din  = pd[g];
          exp_we   = pwe[g];
          if (pwe[g]) begin
            mm[pa[g]] = pd[g];
          end else begin
            q.push_back('{cyc + 1 + RL, g, mm[pa[g]]});
            rh[0] = 1'b1;
          end
          if (plk[g]) lo = g;
          else if (lo == g) lo = -1;
          ptr = (g + 1) % N;
          pv[g] = 0;
        end
      end
      done[c] = 1'b1;
    end
  end

  initial begin
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    for (int t = 0; t < NCYC + 200 && !(done[0] && done[1] && done[2] && done[3]); t++)
      @(posedge clk);
    if (!(done[0] && done[1] && done[2] && done[3])) chk(-1, "timeout", 64'd0, 64'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
